// File: rtl/opl2_led_activity.sv
// Per-channel key-on activity LEDs decoded from the OPL2 register-write bus.
// A keyed-on channel lights its LED solid. On key-off the LED fades out in
// BMAX PWM brightness steps, one step per prescaler tick.

package opl2_led_activity_pkg;
  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
  } opl2_reg_wr_t;
endpackage

// state    | meaning
// ---------+---------------------------------------------------------
// ST_OFF   | channel idle, LED dark
// ST_ON    | channel keyed on, LED solid
// ST_DECAY | key released, LED PWM-dimmed at 'bright', one step per tick
module opl2_led_activity
  import opl2_led_activity_pkg::*;
#(
  parameter int NUM_CH     = 9,
  parameter int ADDR_BASE  = 'hB0,
  parameter int KON_BIT    = 5,
  parameter int DECAY_BITS = 4,
  parameter int TICK_DIV   = 65536
) (
  input  logic              clk,
  input  logic              reset_n,
  input  opl2_reg_wr_t      opl2_reg_wr,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] key_on
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DECAY_BITS-1:0] BMAX = '1;

  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_DECAY} state_t;

  state_t                state_q  [NUM_CH];
  state_t                state_d  [NUM_CH];
  logic [DECAY_BITS-1:0] bright_q [NUM_CH];
  logic [DECAY_BITS-1:0] bright_d [NUM_CH];
  logic [PW-1:0]         presc_q;
  logic [DECAY_BITS-1:0] pwm_q;
  logic [NUM_CH-1:0]     hit;
  logic [NUM_CH-1:0]     led_d;
  logic                  tick;
  logic                  kon;
  logic                  unused_data;

  // Only the key-on bit of the data byte matters here.
  assign kon         = opl2_reg_wr.data[KON_BIT];
  assign unused_data = ^opl2_reg_wr.data;
  assign tick        = (presc_q == PW'(TICK_DIV - 1));

  // Address decode: at most one channel is hit per cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = opl2_reg_wr.valid && (opl2_reg_wr.address == 8'(ADDR_BASE + i));
    end
  end

  // Per-channel next state, brightness and LED drive from the current state.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      bright_d[i] = bright_q[i];
      led_d[i]    = 1'b0;
      case (state_q[i])
        ST_OFF: begin
          if (hit[i] && kon) begin
            state_d[i]  = ST_ON;
            bright_d[i] = BMAX;
          end
        end
        ST_ON: begin
          led_d[i] = 1'b1;
          if (hit[i] && !kon) begin
            state_d[i]  = ST_DECAY;
            bright_d[i] = BMAX;
          end
        end
        ST_DECAY: begin
          led_d[i] = (pwm_q < bright_q[i]);
          // A hit on this channel masks the tick for that cycle.
          if (hit[i]) begin
            if (kon) begin
              state_d[i]  = ST_ON;
              bright_d[i] = BMAX;
            end
          end else if (tick) begin
            if (bright_q[i] > DECAY_BITS'(1)) begin
              bright_d[i] = bright_q[i] - DECAY_BITS'(1);
            end else begin
              bright_d[i] = '0;
              state_d[i]  = ST_OFF;
            end
          end
        end
        default: begin
          state_d[i]  = ST_OFF;
          bright_d[i] = '0;
        end
      endcase
    end
  end

  // State, prescaler, PWM counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      pwm_q   <= '0;
      led     <= '0;
      key_on  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= ST_OFF;
        bright_q[i] <= '0;
      end
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      pwm_q   <= pwm_q + DECAY_BITS'(1);
      led     <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        bright_q[i] <= bright_d[i];
        if (hit[i]) begin
          key_on[i] <= kon;
        end
      end
    end
  end

endmodule

// File: tb/tb_opl2_led_activity.sv
// Directed bench for opl2_led_activity with TICK_DIV=4, DECAY_BITS=2 so that
// the prescaler and the PWM counter run in lockstep from reset release.
module tb_opl2_led_activity;
  import opl2_led_activity_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  opl2_reg_wr_t wr;
  logic [8:0]   led;
  logic [8:0]   key_on;

  string        tag_q[$];
  logic [8:0]   led_q[$];
  logic [8:0]   kon_q[$];

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  logic [13:0] fade_pat;

  always #5 clk = ~clk;

  opl2_led_activity #(
    .NUM_CH(9), .ADDR_BASE('hB0), .KON_BIT(5), .DECAY_BITS(2), .TICK_DIV(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .opl2_reg_wr(wr),
    .led(led),
    .key_on(key_on)
  );

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic push(input string tag, input logic [8:0] l, input logic [8:0] k);
    tag_q.push_back(tag);
    led_q.push_back(l);
    kon_q.push_back(k);
  endtask

  task automatic compare_front();
    string      t;
    logic [8:0] el;
    logic [8:0] ek;
    if (tag_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty observed=none expected=entry");
      return;
    end
    t  = tag_q.pop_front();
    el = led_q.pop_front();
    ek = kon_q.pop_front();
    checks++;
    assert (led === el) else begin
      failures++;
      $error("FAIL %s led observed=%h expected=%h", t, led, el);
    end
    checks++;
    assert (key_on === ek) else begin
      failures++;
      $error("FAIL %s key_on observed=%h expected=%h", t, key_on, ek);
    end
  endtask

  task automatic check_step();
    step();
    compare_front();
  endtask

  // Bus write; returns just after the edge that samples it.
  task automatic bus(input logic v, input logic [7:0] a, input logic [7:0] d);
    wr.valid   = v;
    wr.address = a;
    wr.data    = d;
    step();
    wr = '0;
  endtask

  // Advance until the next edge is one where the prescaler tick is sampled.
  task automatic align_tick();
    while (((ecnt + 1) % 4) != 0) step();
  endtask

  task automatic push_fade(input string tag, input logic [8:0] kon);
    for (int j = 0; j < 14; j++) begin
      push(tag, fade_pat[13-j] ? 9'h008 : 9'h000, kon);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // LED samples after the key-off edge e: brightness 3,2,1 per 4-cycle window, then dark.
    fade_pat = 14'b1110_1100_1000_00;
    wr = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    push("reset", 9'h000, 9'h000);
    compare_front();
    @(negedge clk);
    reset_n = 1'b1;
    ecnt = 0;

    // Key-on ch0: key_on at edge k, led at edge k+1.
    push("t1_kon_k", 9'h000, 9'h001);
    bus(1'b1, 8'hB0, 8'h20);
    compare_front();
    push("t1_led_k1", 9'h001, 9'h001);
    check_step();

    // Writes outside the window or without valid change nothing.
    push("t4_b9_k", 9'h001, 9'h001);
    bus(1'b1, 8'hB9, 8'h20);
    compare_front();
    push("t4_b9_k1", 9'h001, 9'h001);
    check_step();
    push("t4_a0_k", 9'h001, 9'h001);
    bus(1'b1, 8'hA0, 8'h20);
    compare_front();
    push("t4_a0_k1", 9'h001, 9'h001);
    check_step();
    push("t4_novalid_k", 9'h001, 9'h001);
    bus(1'b0, 8'hB0, 8'h00);
    compare_front();
    push("t4_novalid_k1", 9'h001, 9'h001);
    check_step();
    push("t4_df_k", 9'h001, 9'h000);
    bus(1'b1, 8'hB0, 8'hDF);
    compare_front();
    repeat (20) step();
    push("t4_ch0_faded", 9'h000, 9'h000);
    compare_front();

    // Key-on ch3, key-off on a tick edge, full fade.
    push("t2_kon_k", 9'h000, 9'h008);
    bus(1'b1, 8'hB3, 8'h20);
    compare_front();
    push("t2_kon_k1", 9'h008, 9'h008);
    check_step();
    align_tick();
    push("t2_koff_edge", 9'h008, 9'h000);
    bus(1'b1, 8'hB3, 8'h00);
    compare_front();
    push_fade("t2_fade", 9'h000);
    repeat (14) check_step();

    // Retrigger while at brightness 2, then fade again from BMAX.
    push("t3_kon_k", 9'h000, 9'h008);
    bus(1'b1, 8'hB3, 8'h20);
    compare_front();
    align_tick();
    push("t3_koff_edge", 9'h008, 9'h000);
    bus(1'b1, 8'hB3, 8'h00);
    compare_front();
    for (int j = 0; j < 5; j++) push("t3_fade", fade_pat[13-j] ? 9'h008 : 9'h000, 9'h000);
    repeat (5) check_step();
    push("t3_retrig_k", 9'h008, 9'h008);
    bus(1'b1, 8'hB3, 8'h20);
    compare_front();
    for (int j = 0; j < 6; j++) push("t3_on_solid", 9'h008, 9'h008);
    repeat (6) check_step();
    align_tick();
    push("t3_koff2_edge", 9'h008, 9'h000);
    bus(1'b1, 8'hB3, 8'h00);
    compare_front();
    push_fade("t3_refade", 9'h000);
    repeat (14) check_step();

    // Repeated key-off writes during decay do not reload brightness.
    push("t5_kon_k", 9'h000, 9'h008);
    bus(1'b1, 8'hB3, 8'h20);
    compare_front();
    align_tick();
    push("t5_koff_edge", 9'h008, 9'h000);
    bus(1'b1, 8'hB3, 8'h00);
    compare_front();
    push_fade("t5_fade", 9'h000);
    repeat (5) check_step();
    bus(1'b1, 8'hB3, 8'h00);
    compare_front();
    repeat (2) check_step();
    bus(1'b1, 8'hB3, 8'h00);
    compare_front();
    repeat (5) check_step();

    // Async reset mid-fade, then normal key-on latency.
    bus(1'b1, 8'hB5, 8'h20);
    step();
    bus(1'b1, 8'hB3, 8'h20);
    align_tick();
    bus(1'b1, 8'hB3, 8'h00);
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    push("t6_async_rst", 9'h000, 9'h000);
    compare_front();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ecnt = 0;
    push("t6_kon_k", 9'h000, 9'h008);
    bus(1'b1, 8'hB3, 8'h20);
    compare_front();
    push("t6_kon_k1", 9'h008, 9'h008);
    check_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
